// File: rtl/smem_bank_scheduler_pkg.sv
// Shared constants, pass bundle and address helpers for the shared-memory bank scheduler.
// Banks are word-interleaved: bank = addr[5:2], row = addr[ADDR_W-1:6].
package smem_pkg;

    localparam int NUM_LANES = 32;
    localparam int NUM_BANKS = 16;
    localparam int BANK_LOG  = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int WARP_W    = 5;
    localparam int LANE_W    = 5;
    localparam int CNT_W     = 6;
    localparam int BANK_LSB  = 2;
    localparam int ROW_LSB   = BANK_LSB + BANK_LOG;
    localparam int ROW_W     = ADDR_W - ROW_LSB;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [NUM_LANES-1:0]             mask;
        logic [NUM_BANKS-1:0]             en;
        logic [NUM_BANKS-1:0][ROW_W-1:0]  row;
        logic [NUM_BANKS-1:0][LANE_W-1:0] lane;
        logic [NUM_BANKS-1:0][DATA_W-1:0] wdata;
    } pass_t;

    function automatic logic [BANK_LOG-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ROW_LSB-1:BANK_LSB];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ROW_LSB];
    endfunction

endpackage

// File: rtl/smem_bank_scheduler_if.sv
// Request and pass channels of the bank scheduler; slave = scheduler, master = LD/ST side + bank array.
// Both channels are valid/ready; suffixes are named from the scheduler's point of view.
interface smem_bank_scheduler_if #(
    parameter int NUM_LANES = smem_pkg::NUM_LANES,
    parameter int NUM_BANKS = smem_pkg::NUM_BANKS,
    parameter int ADDR_W    = smem_pkg::ADDR_W,
    parameter int DATA_W    = smem_pkg::DATA_W,
    parameter int WARP_W    = smem_pkg::WARP_W
);
    logic                               in_valid_i;
    logic                               in_ready_o;
    logic                               in_load_i;
    logic [WARP_W-1:0]                  in_warp_i;
    logic [NUM_LANES-1:0]               in_mask_i;
    logic [NUM_LANES*ADDR_W-1:0]        in_addr_i;
    logic [NUM_LANES*DATA_W-1:0]        in_wdata_i;

    logic                               pass_valid_o;
    logic                               pass_ready_i;
    logic                               pass_last_o;
    logic                               pass_load_o;
    logic [WARP_W-1:0]                  pass_warp_o;
    logic [NUM_LANES-1:0]               pass_lane_mask_o;
    logic [NUM_BANKS-1:0]               bank_en_o;
    logic [NUM_BANKS*(ADDR_W-6)-1:0]    bank_row_o;
    logic [NUM_BANKS*5-1:0]             bank_lane_o;
    logic [NUM_BANKS*DATA_W-1:0]        bank_wdata_o;
    logic [5:0]                         pass_count_o;

    modport slave (
        input  in_valid_i, in_load_i, in_warp_i, in_mask_i, in_addr_i, in_wdata_i, pass_ready_i,
        output in_ready_o, pass_valid_o, pass_last_o, pass_load_o, pass_warp_o, pass_lane_mask_o,
               bank_en_o, bank_row_o, bank_lane_o, bank_wdata_o, pass_count_o
    );

    modport master (
        output in_valid_i, in_load_i, in_warp_i, in_mask_i, in_addr_i, in_wdata_i, pass_ready_i,
        input  in_ready_o, pass_valid_o, pass_last_o, pass_load_o, pass_warp_o, pass_lane_mask_o,
               bank_en_o, bank_row_o, bank_lane_o, bank_wdata_o, pass_count_o
    );

endinterface

// File: rtl/smem_bank_scheduler_bank_pick.sv
// Per-bank leader pick: lowest pending lane on this bank, plus same-row lanes when loading.
// Purely combinational, no backpressure of its own.
module smem_bank_pick
    import smem_pkg::*;
#(
    parameter int BANK_ID = 0
) (
    input  logic [NUM_LANES-1:0]               i_pending,
    input  logic [NUM_LANES-1:0][BANK_LOG-1:0] i_bank,
    input  logic [NUM_LANES-1:0][ROW_W-1:0]    i_row,
    input  logic                               i_load,
    output logic                               o_en,
    output logic [LANE_W-1:0]                  o_lane,
    output logic [ROW_W-1:0]                   o_row,
    output logic [NUM_LANES-1:0]               o_served
);

    localparam logic [BANK_LOG-1:0] MY_BANK = BANK_LOG'(BANK_ID);

    logic [NUM_LANES-1:0] w_hit;
    logic                 w_found;
    logic [LANE_W-1:0]    w_lead;
    logic [ROW_W-1:0]     w_lead_row;

    always_comb begin
        w_hit      = '0;
        w_found    = 1'b0;
        w_lead     = '0;
        w_lead_row = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_hit[i] = i_pending[i] && (i_bank[i] == MY_BANK);
        end
        // Lowest index wins so stores to one word retire in lane order.
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_found && w_hit[i]) begin
                w_found    = 1'b1;
                w_lead     = LANE_W'(i);
                w_lead_row = i_row[i];
            end
        end
    end

    always_comb begin
        o_served = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_hit[i]) begin
                o_served[i] = i_load ? (i_row[i] == w_lead_row) : (LANE_W'(i) == w_lead);
            end
        end
    end

    assign o_en   = w_found;
    assign o_lane = w_lead;
    assign o_row  = w_lead_row;

endmodule

// File: rtl/smem_bank_scheduler.sv
// Splits a warp shared-memory request into conflict-free bank passes; first pass the cycle after accept,
// one pass per cycle while pass_ready_i is high; a stalled pass holds, and new warps wait until the last pass retires.
module smem_bank_scheduler #(
    parameter int NUM_LANES = smem_pkg::NUM_LANES,
    parameter int NUM_BANKS = smem_pkg::NUM_BANKS,
    parameter int ADDR_W    = smem_pkg::ADDR_W,
    parameter int DATA_W    = smem_pkg::DATA_W,
    parameter int WARP_W    = smem_pkg::WARP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    smem_bank_scheduler_if.slave   io_sched
);
    import smem_pkg::*;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic                                r_load;
    logic [WARP_W-1:0]                   r_warp;
    logic [NUM_LANES-1:0]                r_pending;
    logic [CNT_W-1:0]                    r_count;
    logic [NUM_LANES-1:0][BANK_LOG-1:0]  r_bank;
    logic [NUM_LANES-1:0][ROW_W-1:0]     r_row;
    logic [NUM_LANES-1:0][DATA_W-1:0]    r_wdata;

    logic [NUM_LANES-1:0][BANK_LOG-1:0]  w_in_bank;
    logic [NUM_LANES-1:0][ROW_W-1:0]     w_in_row;
    logic [NUM_LANES-1:0][BANK_LSB-1:0]  w_in_byte;
    logic                                w_unused_byte;

    logic                                w_issue;
    logic                                w_accept;
    logic                                w_fire;
    logic                                w_last;
    logic [NUM_LANES-1:0]                w_served;
    logic [NUM_BANKS-1:0]                w_en;
    logic [NUM_BANKS-1:0][LANE_W-1:0]    w_lane;
    logic [NUM_BANKS-1:0][ROW_W-1:0]     w_row;
    logic [NUM_BANKS-1:0][NUM_LANES-1:0] w_pick_served;
    pass_t                               w_pass;

    always_comb begin
        w_in_bank = '0;
        w_in_row  = '0;
        w_in_byte = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_in_bank[l] = bank_of(io_sched.in_addr_i[l*ADDR_W +: ADDR_W]);
            w_in_row[l]  = row_of(io_sched.in_addr_i[l*ADDR_W +: ADDR_W]);
            w_in_byte[l] = io_sched.in_addr_i[l*ADDR_W +: BANK_LSB];
        end
    end

    // Byte offset inside a word never affects bank selection.
    assign w_unused_byte = ^w_in_byte;

    assign w_issue  = (r_state == ST_ISSUE);
    assign w_accept = (r_state == ST_IDLE) && io_sched.in_valid_i;
    assign w_fire   = w_issue && io_sched.pass_ready_i;
    assign w_last   = (w_served == r_pending);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (io_sched.in_valid_i)  w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_fire && w_last)     w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load    <= 1'b0;
            r_warp    <= '0;
            r_pending <= '0;
            r_count   <= '0;
            r_bank    <= '0;
            r_row     <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_load    <= io_sched.in_load_i;
            r_warp    <= io_sched.in_warp_i;
            r_pending <= io_sched.in_mask_i;
            r_count   <= CNT_W'(1);
            r_bank    <= w_in_bank;
            r_row     <= w_in_row;
            r_wdata   <= io_sched.in_wdata_i;
        end else if (w_fire) begin
            r_pending <= r_pending & ~w_served;
            if (!w_last) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        smem_bank_pick #(
            .BANK_ID (b)
        ) u_pick (
            .i_pending (r_pending),
            .i_bank    (r_bank),
            .i_row     (r_row),
            .i_load    (r_load),
            .o_en      (w_en[b]),
            .o_lane    (w_lane[b]),
            .o_row     (w_row[b]),
            .o_served  (w_pick_served[b])
        );
    end

    always_comb begin
        w_served = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_served = w_served | w_pick_served[b];
        end
    end

    always_comb begin
        w_pass      = '0;
        w_pass.mask = w_issue ? w_served : '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_issue && w_en[b]) begin
                w_pass.en[b]    = 1'b1;
                w_pass.row[b]   = w_row[b];
                w_pass.lane[b]  = w_lane[b];
                w_pass.wdata[b] = r_wdata[w_lane[b]];
            end
        end
    end

    always_comb begin
        io_sched.in_ready_o       = (r_state == ST_IDLE);
        io_sched.pass_valid_o     = w_issue;
        io_sched.pass_last_o      = w_issue && w_last;
        io_sched.pass_load_o      = w_issue && r_load;
        io_sched.pass_warp_o      = w_issue ? r_warp : '0;
        io_sched.pass_count_o     = w_issue ? r_count : '0;
        io_sched.pass_lane_mask_o = w_pass.mask;
        io_sched.bank_en_o        = w_pass.en;
        io_sched.bank_row_o       = w_pass.row;
        io_sched.bank_lane_o      = w_pass.lane;
        io_sched.bank_wdata_o     = w_pass.wdata;
    end

endmodule

// File: tb/tb_smem_bank_scheduler.sv
// Self-checking bench: directed vector table, back-pressure/reset sequence and randomized requests.
module tb_smem_bank_scheduler;
    import smem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    smem_bank_scheduler_if bus();

    smem_bank_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .io_sched (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] t_addr  [32];
    logic [31:0] t_wdata [32];

    logic [31:0] f_mask;
    logic [15:0] f_en;
    logic [4:0]  l_lane0;
    logic [31:0] l_wdata0;
    logic [5:0]  l_count;

    typedef struct {
        int          pat;
        logic        load;
        logic [31:0] mask;
        int          exp_n;
        logic [31:0] exp_first_mask;
        logic [15:0] exp_first_en;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: word address modulo bank count, row = 64-byte line number.
    function automatic int unsigned m_bank(input logic [31:0] a);
        return (a / 32'd4) % 32'd16;
    endfunction

    function automatic int unsigned m_row(input logic [31:0] a);
        return a / 32'd64;
    endfunction

    task automatic model_pass(input logic load, input logic [31:0] pend,
                              output logic [31:0] served, output logic [15:0] en,
                              output logic [15:0][4:0] lead);
        served = '0;
        en     = '0;
        lead   = '0;
        for (int b = 0; b < 16; b++) begin
            for (int l = 0; l < 32; l++) begin
                if (!en[b] && pend[l] && m_bank(t_addr[l]) == b) begin
                    en[b]   = 1'b1;
                    lead[b] = 5'(l);
                end
            end
            for (int l = 0; l < 32; l++) begin
                if (en[b] && pend[l] && m_bank(t_addr[l]) == b) begin
                    if (load ? (m_row(t_addr[l]) == m_row(t_addr[lead[b]])) : (l == int'(lead[b])))
                        served[l] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_pass(input logic load, input logic [4:0] warp, input logic [31:0] pend,
                              input int count, output logic [31:0] served);
        logic [15:0]      en;
        logic [15:0][4:0] lead;
        model_pass(load, pend, served, en, lead);
        chk("pass_valid", bus.pass_valid_o, 1);
        chk("lane_mask", bus.pass_lane_mask_o, served);
        chk("bank_en", bus.bank_en_o, en);
        chk("pass_last", bus.pass_last_o, served == pend);
        chk("pass_count", bus.pass_count_o, count);
        chk("pass_attr", {bus.pass_load_o, bus.pass_warp_o}, {load, warp});
        for (int b = 0; b < 16; b++) begin
            if (en[b]) begin
                chk("bank_row_lane", {bus.bank_row_o[b*ROW_W +: ROW_W], bus.bank_lane_o[b*5 +: 5]},
                    {ROW_W'(m_row(t_addr[lead[b]])), lead[b]});
                chk("bank_wdata", bus.bank_wdata_o[b*32 +: 32], t_wdata[lead[b]]);
            end
        end
    endtask

    task automatic run_request(input logic load, input logic [31:0] mask, input logic [4:0] warp,
                               input int stall_at, input int stop_at, input bit rand_bp,
                               output int npass);
        logic [31:0] pend;
        logic [31:0] served;
        int          count;
        int          k;
        bit          last;
        bus.in_load_i = load;
        bus.in_warp_i = warp;
        bus.in_mask_i = mask;
        for (int l = 0; l < 32; l++) begin
            bus.in_addr_i[l*32 +: 32]  = t_addr[l];
            bus.in_wdata_i[l*32 +: 32] = t_wdata[l];
        end
        bus.in_valid_i = 1'b1;
        for (int w = 0; w < 50 && !bus.in_ready_o; w++) tick();
        chk("accept_ready", bus.in_ready_o, 1);
        tick();
        bus.in_valid_i = 1'b0;
        chk("busy_ready", bus.in_ready_o, 0);
        pend  = mask;
        count = 1;
        npass = 0;
        for (int p = 0; p < 40; p++) begin
            check_pass(load, warp, pend, count, served);
            npass++;
            if (p == 0) begin
                f_mask = bus.pass_lane_mask_o;
                f_en   = bus.bank_en_o;
            end
            k = (p + 1 == stall_at) ? 3 : (rand_bp ? int'($urandom_range(0, 2)) : 0);
            if (k > 0) begin
                bus.pass_ready_i = 1'b0;
                for (int s = 0; s < k; s++) begin
                    tick();
                    check_pass(load, warp, pend, count, served);
                end
                bus.pass_ready_i = 1'b1;
            end
            if (p + 1 == stop_at) return;
            last     = (served == pend);
            l_lane0  = bus.bank_lane_o[4:0];
            l_wdata0 = bus.bank_wdata_o[31:0];
            l_count  = bus.pass_count_o;
            tick();
            pend  = pend & ~served;
            count = count + 1;
            if (last) break;
        end
        chk("done_ready", bus.in_ready_o, 1);
        chk("done_valid", bus.pass_valid_o, 0);
    endtask

    task automatic set_pattern(input int pat);
        for (int l = 0; l < 32; l++) begin
            case (pat)
                0:       t_addr[l] = 32'(l * 4);
                1:       t_addr[l] = 32'h100;
                2:       t_addr[l] = 32'(l * 64);
                default: t_addr[l] = 32'h80;
            endcase
            t_wdata[l] = 32'hD000_0000 + 32'(l * 32'h101);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_ready"}, bus.in_ready_o, 1);
        chk({nm, "_valid"}, bus.pass_valid_o, 0);
        chk({nm, "_mask_en_last"}, {bus.pass_lane_mask_o, bus.bank_en_o, bus.pass_last_o}, 0);
        chk({nm, "_count_attr"}, {bus.pass_count_o, bus.pass_load_o, bus.pass_warp_o}, 0);
        chk({nm, "_bank_data"}, {|bus.bank_row_o, |bus.bank_lane_o, |bus.bank_wdata_o}, 0);
    endtask

    initial begin
        int np;
        vt[0] = '{0, 1'b1, 32'hFFFF_FFFF, 2,  32'h0000_FFFF, 16'hFFFF};
        vt[1] = '{1, 1'b1, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFF, 16'h0001};
        vt[2] = '{2, 1'b1, 32'hFFFF_FFFF, 32, 32'h0000_0001, 16'h0001};
        vt[3] = '{3, 1'b0, 32'hFFFF_FFFF, 32, 32'h0000_0001, 16'h0001};
        vt[4] = '{0, 1'b1, 32'h0000_0000, 1,  32'h0000_0000, 16'h0000};

        reset            = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.in_load_i    = 1'b0;
        bus.in_warp_i    = '0;
        bus.in_mask_i    = '0;
        bus.in_addr_i    = '0;
        bus.in_wdata_i   = '0;
        bus.pass_ready_i = 1'b1;
        #1;
        check_idle_outputs("in_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("after_reset");

        for (int v = 0; v < 5; v++) begin
            set_pattern(vt[v].pat);
            run_request(vt[v].load, vt[v].mask, 5'(v + 3), 0, 0, 1'b0, np);
            chk("vec_passes", np, vt[v].exp_n);
            chk("vec_first_mask", f_mask, vt[v].exp_first_mask);
            chk("vec_first_en", f_en, vt[v].exp_first_en);
            chk("vec_last_count", l_count, vt[v].exp_n);
            if (vt[v].pat == 1) chk("bcast_row", bus.bank_row_o[ROW_W-1:0], 0);
            if (vt[v].pat == 3) chk("store_last_lane", {l_lane0, l_wdata0}, {5'd31, t_wdata[31]});
            tick();
        end

        // Stall pass 2 for three cycles, then reset while pass 5 is presented.
        set_pattern(2);
        run_request(1'b1, 32'hFFFF_FFFF, 5'd9, 2, 5, 1'b0, np);
        chk("stop_pass_count", bus.pass_count_o, 5);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("post_reset");
        set_pattern(0);
        run_request(1'b1, 32'hFFFF_FFFF, 5'd1, 0, 0, 1'b0, np);
        chk("post_reset_passes", np, 2);

        for (int r = 0; r < 25; r++) begin
            logic [31:0] m;
            logic        ld;
            ld = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       m = 32'hFFFF_FFFF;
                1:       m = $urandom;
                2:       m = $urandom & $urandom;
                default: m = (r % 5 == 0) ? 32'h0 : $urandom | $urandom;
            endcase
            for (int l = 0; l < 32; l++) begin
                t_addr[l]  = 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, (r % 2) ? 3 : 15) << 2)
                           | 32'($urandom_range(0, 3));
                t_wdata[l] = $urandom;
            end
            run_request(ld, m, 5'($urandom_range(0, 31)), 0, 0, 1'b1, np);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/smem_bank_scheduler.md
# smem_bank_scheduler

Shared-memory bank-conflict scheduler for the load/store unit. It accepts one warp-wide shared-memory request (32 lane addresses, store data, active mask) and splits it into conflict-free passes over the 16 word-interleaved banks, issuing one pass per handshake. While a request is being serialised it holds off the next warp. It sits between the LD/ST address-generation stage and the shared-memory bank array.

## Interface
Parameters:
- NUM_LANES, 32, lanes per warp (`SIZE_CORE`)
- NUM_BANKS, 16, shared-memory banks; power of two
- ADDR_W, 32, byte address width (`SIZE_ADDR`)
- DATA_W, 32, data width (`SIZE_DATA`)
- WARP_W, `NUM_WARP_LOG`, warp id width

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  scheduler can accept a request
- in_load_i  input  1  1 = load, 0 = store
- in_warp_i  input  WARP_W  warp id
- in_mask_i  input  NUM_LANES  active lanes
- in_addr_i  input  NUM_LANES*ADDR_W  lane byte addresses, lane 0 in LSBs
- in_wdata_i  input  NUM_LANES*DATA_W  lane store data, lane 0 in LSBs
- pass_valid_o  output  1  pass presented
- pass_ready_i  input  1  bank array accepts pass
- pass_last_o  output  1  final pass of current request
- pass_load_o / pass_warp_o  output  1 / WARP_W  request attributes
- pass_lane_mask_o  output  NUM_LANES  lanes served this pass
- bank_en_o  output  NUM_BANKS  bank access enables
- bank_row_o  output  NUM_BANKS*(ADDR_W-6)  row address per bank (byte addr >> 6)
- bank_lane_o  output  NUM_BANKS*5  lane index owning each bank
- bank_wdata_o  output  NUM_BANKS*DATA_W  store data per bank
- pass_count_o  output  6  passes issued for current request, including presented one

## Operation
- Bank of a lane = addr[5:2]; row = addr[ADDR_W-1:6]; addr[1:0] ignored.
- States: IDLE, ISSUE. in_ready_o = (state == IDLE).
- IDLE: on in_valid_i & in_ready_o, latch all inputs; pending = in_mask_i; pass_count = 1; go ISSUE.
- ISSUE: each bank selects the lowest-index pending lane mapped to it (the leader).
  - Load: every pending lane with the same bank and row as the leader is also served (broadcast).
  - Store: only the leader is served; no merging. Lanes issue in ascending order, so the highest same-address lane writes last and wins.
- Pass outputs are combinational from registered state only. There is no input-to-output path.
- pass_last_o = 1 when served lanes equal pending.
- On pass_valid_o & pass_ready_i:
  - pending &= ~served; pass_count++.
  - If pass_last_o, go IDLE.
- Empty mask is accepted. It produces exactly one pass with bank_en_o = 0, lane mask 0, last = 1.
- Maximum is 32 passes (all lanes in one bank, distinct rows/stores). A 6-bit count never wraps.
- Reset (any time, including mid-request): state IDLE, pending 0. The in-flight request is dropped with no completion.

## Timing
- Reset values:
  - in_ready_o = 1 during and after reset.
  - All other outputs 0.
- Request accepted at edge T. First pass valid in the cycle after T.
- N passes take N cycles with pass_ready_i held high.
- in_ready_o rises the cycle after the last pass handshake. Back-to-back warps therefore see one bubble cycle.
- pass_ready_i low: all pass outputs hold stable; pending is unchanged.
- in_valid_i while busy: ignored (in_ready_o = 0). The source must hold the request.

## Structure
- Shared package `smem_pkg`:
  - NUM_BANKS, BANK_LOG = 4, bank/row bit-slice constants.
  - Function bank_of(addr).
  - Pass-bundle typedef (mask, en, row, lane, wdata).
- Sub-module `smem_bank_pick`:
  - One instance per bank.
  - Inputs: pending mask, lane banks/rows, load flag.
  - Outputs: enable, leader lane, row, served-lane vector.
  - The top ORs the served vectors from all instances to form pass_lane_mask_o.

## Test plan
- Stride-4 load, addr = lane*4, full mask -> 2 passes:
  - Pass 1: mask 0x0000FFFF, pass_count 1.
  - Pass 2: mask 0xFFFF0000, last = 1.
- Broadcast load, all lanes addr 0x100, full mask -> 1 pass, mask 0xFFFFFFFF, bank_en_o = 0x0001, row 4, last = 1.
- Stride-64 load, addr = lane*0x40 -> 32 passes, one lane each, ascending 0..31, all bank 0. last only on pass 32, pass_count_o = 32.
- Store, all lanes addr 0x80 -> 32 single-lane passes. Final pass is lane 31 with bank_wdata_o[0] = lane-31 data.
- Mask 0 -> one pass, bank_en_o = 0, last = 1. in_ready_o is high the following cycle.
- Back-pressure then reset:
  - pass_ready_i low 3 cycles at pass 2 of stride-64 -> outputs stable.
  - Assert reset at pass 5 -> all outputs 0 asynchronously.
  - After release, in_ready_o = 1 and a new request issues from pass 1.
